// File: rtl/jh512_padder_if.sv
// rtl/jh512_padder_if.sv - word-in / block-out handshake bundle for the JH512 padder
interface jh512_padder_if;
    logic [63:0]  in_data;
    logic [3:0]   in_bytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready;

    modport master (
        output in_data, in_bytes, in_last, in_valid, blk_ready,
        input  in_ready, blk_data, blk_first, blk_last, blk_valid
    );

    modport slave (
        input  in_data, in_bytes, in_last, in_valid, blk_ready,
        output in_ready, blk_data, blk_first, blk_last, blk_valid
    );
endinterface

// File: rtl/jh512_padder.sv
// rtl/jh512_padder.sv - JH512 message padder: 64-bit words in, padded 512-bit blocks out
module jh512_padder (
    input  logic          clk,
    input  logic          rst,
    jh512_padder_if.slave bus
);
    localparam int WORD_W = 64;
    localparam int BLK_W  = 512;
    localparam int LEN_W  = 128;

    typedef enum logic [1:0] {ABSORB, EMIT_DATA, EMIT_FINAL} state_t;

    state_t             state_q, state_d;
    logic [2:0]         widx_q, widx_d;
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               first_q, first_d;
    logic               marker_q, marker_d;
    logic               pending_q, pending_d;
    logic               blk_valid_q, blk_valid_d;
    logic               blk_first_q, blk_first_d;
    logic               blk_last_q, blk_last_d;
    logic [BLK_W-1:0]   blk_data_q, blk_data_d;

    logic [WORD_W-1:0]  word_m;
    logic [6:0]         mp;
    logic               in_hs, out_hs, load_data;

    always_comb begin
        in_hs  = bus.in_valid && (state_q == ABSORB);
        out_hs = blk_valid_q && bus.blk_ready;
        word_m = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < bus.in_bytes)
                word_m[(7-b)*8 +: 8] = bus.in_data[(7-b)*8 +: 8];
        end
        mp = {1'b0, widx_q, 3'b000} + {3'b000, bus.in_bytes};

        state_d     = state_q;
        widx_d      = widx_q;
        buf_d       = buf_q;
        len_d       = len_q;
        first_d     = first_q;
        marker_d    = marker_q;
        pending_d   = pending_q;
        blk_valid_d = blk_valid_q;
        blk_first_d = blk_first_q;
        blk_last_d  = blk_last_q;
        blk_data_d  = blk_data_q;
        load_data   = 1'b0;

        case (state_q)
            ABSORB: begin
                if (in_hs) begin
                    for (int s = 0; s < 8; s++) begin
                        if (widx_q == 3'(s))
                            buf_d[(7-s)*64 +: 64] = word_m;
                    end
                    len_d = len_q + {121'b0, bus.in_bytes, 3'b000};
                    if (!bus.in_last) begin
                        if (widx_q == 3'd7) begin
                            state_d   = EMIT_DATA;
                            pending_d = 1'b0;
                            load_data = 1'b1;
                        end else begin
                            widx_d = widx_q + 3'd1;
                        end
                    end else if (mp == 7'd0) begin
                        // Message ends on a block boundary: only the length block follows
                        state_d     = EMIT_FINAL;
                        marker_d    = 1'b1;
                        blk_valid_d = 1'b1;
                        blk_first_d = first_q;
                        blk_last_d  = 1'b1;
                        blk_data_d  = {8'h80, 376'b0, len_d};
                    end else begin
                        for (int i = 1; i < 64; i++) begin
                            if (mp == 7'(i))
                                buf_d[(63-i)*8 +: 8] = 8'h80;
                        end
                        state_d   = EMIT_DATA;
                        pending_d = 1'b1;
                        marker_d  = (mp == 7'd64);
                        load_data = 1'b1;
                    end
                end
            end
            EMIT_DATA: begin
                if (out_hs) begin
                    buf_d   = '0;
                    widx_d  = 3'd0;
                    first_d = 1'b0;
                    if (pending_q) begin
                        state_d     = EMIT_FINAL;
                        blk_valid_d = 1'b1;
                        blk_first_d = 1'b0;
                        blk_last_d  = 1'b1;
                        blk_data_d  = {marker_q ? 8'h80 : 8'h00, 376'b0, len_q};
                    end else begin
                        state_d     = ABSORB;
                        blk_valid_d = 1'b0;
                        blk_first_d = 1'b0;
                        blk_last_d  = 1'b0;
                    end
                end
            end
            EMIT_FINAL: begin
                if (out_hs) begin
                    state_d     = ABSORB;
                    len_d       = '0;
                    first_d     = 1'b1;
                    marker_d    = 1'b0;
                    pending_d   = 1'b0;
                    widx_d      = 3'd0;
                    blk_valid_d = 1'b0;
                    blk_first_d = 1'b0;
                    blk_last_d  = 1'b0;
                end
            end
            default: state_d = ABSORB;
        endcase

        // Data block goes out with the just-written word and marker included
        if (load_data) begin
            blk_valid_d = 1'b1;
            blk_first_d = first_q;
            blk_last_d  = 1'b0;
            blk_data_d  = buf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ABSORB;
            widx_q      <= 3'd0;
            buf_q       <= '0;
            len_q       <= '0;
            first_q     <= 1'b1;
            marker_q    <= 1'b0;
            pending_q   <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            blk_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            first_q     <= first_d;
            marker_q    <= marker_d;
            pending_q   <= pending_d;
            blk_valid_q <= blk_valid_d;
            blk_first_q <= blk_first_d;
            blk_last_q  <= blk_last_d;
            blk_data_q  <= blk_data_d;
        end
    end

    assign bus.in_ready  = !rst && (state_q == ABSORB);
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_last  = blk_last_q;
    assign bus.blk_data  = blk_data_q;
endmodule

// File: tb/tb_jh512_padder.sv
// tb/tb_jh512_padder.sv - scoreboard bench for the JH512 padder
module tb_jh512_padder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jh512_padder_if ifc ();
    jh512_padder dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } exp_t;

    exp_t         sbq[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [7:0]   msg [0:255];
    bit           bp_mode = 0;
    bit           hs_prev = 0;
    bit           held = 0;
    logic [511:0] held_d;
    logic         held_f, held_l;
    int           vcnt = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held    = 0;
            hs_prev = 0;
        end else begin
            if (held) begin
                chk("hold_valid", 512'(ifc.blk_valid), 512'(1));
                chk("hold_data", ifc.blk_data, held_d);
                chk("hold_first", 512'(ifc.blk_first), 512'(held_f));
                chk("hold_last", 512'(ifc.blk_last), 512'(held_l));
            end
            if (ifc.blk_valid)
                chk("in_ready_while_emit", 512'(ifc.in_ready), 512'(0));
            if (ifc.blk_valid && ifc.blk_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_block", 512'(ifc.blk_valid), 512'(0));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("blk_data", ifc.blk_data, e.d);
                    chk("blk_first", 512'(ifc.blk_first), 512'(e.f));
                    chk("blk_last", 512'(ifc.blk_last), 512'(e.l));
                end
            end
            held    = ifc.blk_valid && !ifc.blk_ready;
            held_d  = ifc.blk_data;
            held_f  = ifc.blk_first;
            held_l  = ifc.blk_last;
            hs_prev = ifc.blk_valid && ifc.blk_ready;
        end
    end

    initial begin
        ifc.blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_prev) vcnt = 0;
            if (ifc.blk_valid) vcnt++;
            else vcnt = 0;
            ifc.blk_ready = !bp_mode || (vcnt > 5);
        end
    end

    task automatic push_expected(input int n);
        int nd;
        logic [511:0] blk;
        logic [7:0] v;
        nd = (n + 63) / 64;
        for (int b = 0; b < nd; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) begin
                int idx;
                idx = b * 64 + j;
                if (idx < n) v = msg[idx];
                else if (idx == n) v = 8'h80;
                else v = 8'h00;
                blk[(63-j)*8 +: 8] = v;
            end
            sbq.push_back('{blk, (b == 0), 1'b0});
        end
        blk = '0;
        blk[127:0] = 128'(n) << 3;
        blk[511:504] = ((n % 64) == 0) ? 8'h80 : 8'h00;
        sbq.push_back('{blk, (nd == 0), 1'b1});
    endtask

    task automatic drive_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
        int t;
        t = 0;
        ifc.in_data  = d;
        ifc.in_bytes = nb;
        ifc.in_last  = last;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        while (!ifc.in_ready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!ifc.in_ready) chk("in_ready_timeout", 512'(ifc.in_ready), 512'(1));
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_msg(input int n, input bit ab, input bit extra_empty);
        int nw;
        logic [63:0] d;
        for (int i = 0; i < n; i++) msg[i] = 8'($urandom_range(0, 255));
        if (ab) msg[0] = 8'hAB;
        push_expected(n);
        nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            int nb;
            d = {$urandom, $urandom};
            nb = (n - 8 * w > 8) ? 8 : n - 8 * w;
            for (int j = 0; j < nb; j++) d[(7-j)*8 +: 8] = msg[w*8+j];
            drive_word(d, 4'(nb), (w == nw - 1) && !extra_empty);
        end
        if (extra_empty) drive_word({$urandom, $urandom}, 4'd0, 1'b1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 3000) begin
            t++;
            @(negedge clk);
        end
        chk("drain_pending", 512'(sbq.size()), 512'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.in_bytes = '0;
        ifc.in_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 512'(ifc.in_ready), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 512'(ifc.in_ready), 512'(1));
        chk("reset_blk_valid", 512'(ifc.blk_valid), 512'(0));
        chk("reset_blk_data", ifc.blk_data, 512'(0));
        chk("reset_flags", 512'({ifc.blk_first, ifc.blk_last}), 512'(0));
        @(posedge clk);
        #1;

        send_msg(0, 0, 0);
        wait_drain();
        send_msg(1, 1, 0);
        wait_drain();
        send_msg(64, 0, 0);
        wait_drain();
        send_msg(120, 0, 0);
        wait_drain();
        send_msg(64, 0, 1);
        wait_drain();
        send_msg(57, 0, 0);
        wait_drain();

        bp_mode = 1;
        send_msg(13, 0, 0);
        send_msg(70, 0, 0);
        wait_drain();
        bp_mode = 0;

        for (int w = 0; w < 3; w++) drive_word({$urandom, $urandom}, 4'd8, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 512'(ifc.in_ready), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_msg(1, 1, 0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jh512_padder.md
Name: jh512_padder

Overview:
- Upstream message-formatting stage for the JH512 compression core.
- Accepts a byte-aligned message as a stream of 64-bit big-endian words and applies JH padding: a 0x80 marker byte, zero fill, and a 128-bit big-endian bit-length.
- Emits 512-bit blocks with first/last flags over a valid/ready handshake.
- Single block buffer: input and output never overlap.

Parameters:
- WORD_W, 64, input word width in bits; fixed (8 words per block).
- BLK_W, 512, output block width in bits; fixed.
- LEN_W, 128, message-length counter width in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  64  message word; byte 0 = bits 63:56.
- in_bytes  in  4  valid bytes in the word, 0..8. Must be 8 unless in_last. 0 is legal only with in_last.
- in_last  in  1  final word of the message.
- in_valid  in  1  word present.
- in_ready  out  1  word accepted when in_valid && in_ready.
- blk_data  out  512  padded block; byte 0 = bits 511:504.
- blk_first  out  1  first block of the message.
- blk_last  out  1  final block of the message (carries the length).
- blk_valid  out  1  block present; held stable until accepted.
- blk_ready  in  1  downstream accepts when blk_valid && blk_ready.

Behaviour:
- Reset: state=ABSORB, widx=0, buffer=0, len=0, first_flag=1, marker_flag=0, pending_final=0, blk_valid=0, blk_first=0, blk_last=0, blk_data=0.
- in_ready=0 while rst is high. in_ready=1 exactly when state==ABSORB.
- Reset mid-message discards all partial data and length. Any block in flight is dropped.
- Accepted word:
  - Bytes at index >= in_bytes are masked to 0.
  - Word written to buffer slot widx (slot 0 = bits 511:448).
  - len += 8*in_bytes, modulo 2^128.
- ABSORB transitions:
  - Not last, widx<7: widx++.
  - Not last, widx==7: go to EMIT_DATA with pending_final=0.
  - Last: compute mp = 8*widx + in_bytes (byte offset in block, 0..64).
    - mp==0: go to EMIT_FINAL with marker_flag=1. No data block is emitted; this covers the empty message and block-aligned endings.
    - mp==64: go to EMIT_DATA with pending_final=1, marker_flag=1.
    - Otherwise: write 0x80 at byte mp, zero all later bytes, go to EMIT_DATA with pending_final=1, marker_flag=0.
- EMIT_DATA:
  - blk_valid=1, blk_data=buffer, blk_first=first_flag, blk_last=0.
  - On handshake: clear buffer, widx=0, first_flag=0. Go to EMIT_FINAL if pending_final, else ABSORB.
- EMIT_FINAL:
  - blk_valid=1, blk_last=1, blk_first=first_flag.
  - blk_data = {marker_flag ? 8'h80 : 8'h00, 376'b0, len}.
  - On handshake: len=0, first_flag=1, marker_flag=0, pending_final=0, widx=0. Go to ABSORB.
- Outputs are registered. blk_valid rises the cycle after the completing word is accepted.
- Minimum throughput: 8 input cycles plus 1 output cycle per block at blk_ready=1.
- Blocks per message = ceil(l/512)+1, where l = message length in bits. The final block never carries message bytes.
- blk_data, blk_first and blk_last do not change while blk_valid && !blk_ready.

Test Plan:
- Empty message: one word, in_bytes=0, in_last=1 -> one block, first=last=1, byte0=0x80, all else 0, length field = 0.
- One byte 0xAB -> block0: byte0=0xAB, byte1=0x80, rest 0, first=1, last=0. Block1: all 0 except low 128 bits = 8, last=1.
- 64 bytes (8 full words, last on word 8) -> data block equals input. Final block: byte0=0x80, len=512, blk_first only on block0.
- 120 bytes (15 words) -> block1 word7 = 0x80 followed by zeros. Final block byte0=0x00, len=960. Three blocks total.
- Backpressure: hold blk_ready=0 for 5 cycles on each block -> blk_data/flags stable, in_ready=0 throughout, no word lost. Two back-to-back messages padded independently, with len restarting at 0.
- Reset mid-operation: assert rst after 3 words of a message, then send a 1-byte message -> output identical to the one-byte case, with no residue from the aborted message.
